// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_resp_state_t;

  localparam int WORD_W = 32;

  // Misaligned or beyond the last word of the array.
  function automatic logic is_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (32'(addr[WORD_W-1:2]) >= depth);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word array with per-byte write mask and a registered read capture that can be cleared.
module dmem_ram
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [3:0]        be_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rdata_q <= '0;
    else if (clr_i) rdata_q <= '0;
    else if (re_i)  rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, programmable latency, valid/ready response out.
// Optional byte-enable store path when DMEM_RESP_BYTEEN_EN is defined.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [WORD_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
`ifdef DMEM_RESP_BYTEEN_EN
  input  logic [3:0]        req_be_i,
`endif
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [WORD_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  dmem_resp_state_t  state_q;
  logic [CW-1:0]     cnt_q;
  logic              we_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [3:0]        be_q, be_in;
  logic              resp_valid_q, resp_err_q;
  logic              accept, commit, done;

`ifdef DMEM_RESP_BYTEEN_EN
  assign be_in = req_be_i;
`else
  assign be_in = 4'hF;
`endif

  assign req_ready_o = (state_q == IDLE) && !reset;
  assign accept      = req_valid_i && req_ready_o;
  // Counter is loaded with LATENCY and commits when it sits at 1, so the
  // commit edge lands exactly LATENCY edges after accept for every legal value.
  assign commit      = (state_q == WAIT) && (cnt_q == CW'(1));
  assign done        = (state_q == RESP) && resp_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          we_q    <= req_we_i;
          err_q   <= is_err(req_addr_i, DEPTH);
          idx_q   <= req_addr_i[2 +: AW];
          wdata_q <= req_wdata_i;
          be_q    <= be_in;
          cnt_q   <= CW'(LATENCY);
          state_q <= WAIT;
        end
        WAIT: if (commit) begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_q;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        RESP: if (resp_ready_i) begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is captured only for legal loads; it is otherwise held at zero.
  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (commit && we_q && !err_q),
    .re_i    (commit && !we_q && !err_q),
    .clr_i   (done),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (resp_rdata_o)
  );

  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
`ifdef DMEM_RESP_BYTEEN_EN
  logic [3:0]  req_be    [2];
`endif
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m   [2][DEPTH];
  logic        known_m [2][DEPTH];

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rdy_acc;
    logic        stable;
    logic        idle_after;
  } obs_t;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
`ifdef DMEM_RESP_BYTEEN_EN
    .req_be_i(req_be[0]),
`endif
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
`ifdef DMEM_RESP_BYTEEN_EN
    .req_be_i(req_be[1]),
`endif
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
  );

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  // Reference: a plain word array; errors never touch it, stores merge enabled bytes.
  function automatic void model_acc(input int s, input logic we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] be,
                                    output logic [31:0] rd, output logic er);
    int  w;
    logic full;
    w  = int'(a >> 2);
    er = (a % 4 != 0) || (w >= DEPTH);
    rd = 32'h0;
`ifdef DMEM_RESP_BYTEEN_EN
    full = (be == 4'hF);
`else
    full = 1'b1;
`endif
    if (!er && we) begin
      for (int b = 0; b < 4; b++) begin
`ifdef DMEM_RESP_BYTEEN_EN
        if (be[b])
`endif
          mem_m[s][w][8*b +: 8] = wd[8*b +: 8];
      end
      if (full) known_m[s][w] = 1'b1;
    end else if (!er) begin
      rd = mem_m[s][w];
    end
  endfunction

  // Drives one access on instance s and records what the responder did; no judging here.
  task automatic xact(input int s, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int hold, output obs_t o);
    o.lat = -1; o.stable = 1'b1; o.rd = 32'h0; o.er = 1'b0; o.idle_after = 1'b0;
    @(negedge clk);
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = a; req_wdata[s] = wd;
`ifdef DMEM_RESP_BYTEEN_EN
    req_be[s] = be;
`endif
    resp_ready[s] = 1'b0;
    @(posedge clk); #1;
    o.rdy_acc = req_ready[s];
    req_valid[s] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (resp_valid[s]) begin o.lat = k; break; end
    end
    if (o.lat < 0) return;
    o.rd = resp_rdata[s]; o.er = resp_err[s];
    repeat (hold) begin
      @(posedge clk); #1;
      if (!resp_valid[s] || resp_rdata[s] !== o.rd || resp_err[s] !== o.er || req_ready[s] !== 1'b0)
        o.stable = 1'b0;
    end
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready[s] = 1'b0;
    o.idle_after = (req_ready[s] === 1'b1) && (resp_valid[s] === 1'b0) &&
                   (resp_rdata[s] === 32'h0) && (resp_err[s] === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++; if (req_ready[s] !== 1'b0) begin errors++; $display("FAIL rst_ready[%0d] got %b want 0", s, req_ready[s]); end
      checks++; if (resp_valid[s] !== 1'b0) begin errors++; $display("FAIL rst_valid[%0d] got %b want 0", s, resp_valid[s]); end
      checks++; if (resp_rdata[s] !== 32'h0) begin errors++; $display("FAIL rst_rdata[%0d] got %h want 0", s, resp_rdata[s]); end
      checks++; if (resp_err[s] !== 1'b0) begin errors++; $display("FAIL rst_err[%0d] got %b want 0", s, resp_err[s]); end
    end
    @(negedge clk); reset = 1'b0; #1;
    for (int s = 0; s < 2; s++) begin
      checks++; if (req_ready[s] !== 1'b1) begin errors++; $display("FAIL idle_ready[%0d] got %b want 1", s, req_ready[s]); end
    end
  endtask

  task automatic test_store_load(input int s);
    obs_t o; logic [31:0] er_d; logic ee;
    model_acc(s, 1'b1, 32'd84, 32'h7, 4'hF, er_d, ee);
    xact(s, 1'b1, 32'd84, 32'h7, 4'hF, 0, o);
    checks++; if (o.rdy_acc !== 1'b0) begin errors++; $display("FAIL st_ready_drop[%0d] got %b want 0", s, o.rdy_acc); end
    checks++; if (o.lat != lat_of(s)) begin errors++; $display("FAIL st_latency[%0d] got %0d want %0d", s, o.lat, lat_of(s)); end
    checks++; if (o.er !== ee || o.rd !== er_d) begin errors++; $display("FAIL st_resp[%0d] got err %b rd %h want err %b rd %h", s, o.er, o.rd, ee, er_d); end
    checks++; if (!o.idle_after) begin errors++; $display("FAIL st_idle[%0d] got 0 want 1", s); end
    model_acc(s, 1'b0, 32'd84, 32'h0, 4'hF, er_d, ee);
    xact(s, 1'b0, 32'd84, 32'h0, 4'hF, 0, o);
    checks++; if (o.lat != lat_of(s)) begin errors++; $display("FAIL ld_latency[%0d] got %0d want %0d", s, o.lat, lat_of(s)); end
    checks++; if (o.rd !== 32'h7 || o.er !== 1'b0) begin errors++; $display("FAIL ld84[%0d] got err %b rd %h want err 0 rd 00000007", s, o.er, o.rd); end
  endtask

  task automatic test_hold(input int s);
    obs_t o;
    xact(s, 1'b0, 32'd84, 32'h0, 4'hF, 5, o);
    checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL hold_stable[%0d] got 0 want 1", s); end
    checks++; if (o.rd !== 32'h7) begin errors++; $display("FAIL hold_rdata[%0d] got %h want 00000007", s, o.rd); end
    checks++; if (!o.idle_after) begin errors++; $display("FAIL hold_release[%0d] got 0 want 1", s); end
  endtask

  task automatic test_misaligned();
    obs_t o; logic [31:0] rd; logic er;
    model_acc(0, 1'b1, 32'd80, 32'h1234_5678, 4'hF, rd, er);
    xact(0, 1'b1, 32'd80, 32'h1234_5678, 4'hF, 0, o);
    model_acc(0, 1'b1, 32'h52, 32'h55, 4'hF, rd, er);
    xact(0, 1'b1, 32'h52, 32'h55, 4'hF, 0, o);
    checks++; if (o.er !== 1'b1 || o.rd !== 32'h0) begin errors++; $display("FAIL misalign got err %b rd %h want err 1 rd 0", o.er, o.rd); end
    checks++; if (o.lat != 2) begin errors++; $display("FAIL misalign_lat got %0d want 2", o.lat); end
    model_acc(0, 1'b0, 32'd80, 32'h0, 4'hF, rd, er);
    xact(0, 1'b0, 32'd80, 32'h0, 4'hF, 0, o);
    checks++; if (o.rd !== rd || o.er !== er) begin errors++; $display("FAIL misalign_nowrite got rd %h want %h", o.rd, rd); end
  endtask

  task automatic test_range();
    obs_t o; logic [31:0] rd; logic er;
    model_acc(0, 1'b1, 32'd252, 32'hCAFE_0001, 4'hF, rd, er);
    xact(0, 1'b1, 32'd252, 32'hCAFE_0001, 4'hF, 0, o);
    xact(0, 1'b0, 32'd256, 32'h0, 4'hF, 0, o);
    checks++; if (o.er !== 1'b1 || o.rd !== 32'h0) begin errors++; $display("FAIL range256 got err %b rd %h want err 1 rd 0", o.er, o.rd); end
    model_acc(0, 1'b0, 32'd252, 32'h0, 4'hF, rd, er);
    xact(0, 1'b0, 32'd252, 32'h0, 4'hF, 0, o);
    checks++; if (o.er !== 1'b0 || o.rd !== 32'hCAFE_0001) begin errors++; $display("FAIL range252 got err %b rd %h want err 0 rd cafe0001", o.er, o.rd); end
  endtask

  task automatic test_reset_wait();
    obs_t o; logic [31:0] rd; logic er;
    model_acc(0, 1'b1, 32'd88, 32'h1, 4'hF, rd, er);
    xact(0, 1'b1, 32'd88, 32'h1, 4'hF, 0, o);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'd88; req_wdata[0] = 32'hDEAD_BEEF;
`ifdef DMEM_RESP_BYTEEN_EN
    req_be[0] = 4'hF;
`endif
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reset = 1'b1; #1;
    checks++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin errors++; $display("FAIL rstwait_in got valid %b ready %b want 0 0", resp_valid[0], req_ready[0]); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin errors++; $display("FAIL rstwait_out got ready %b valid %b want 1 0", req_ready[0], resp_valid[0]); end
    xact(0, 1'b0, 32'd88, 32'h0, 4'hF, 0, o);
    checks++; if (o.rd !== 32'h1 || o.er !== 1'b0) begin errors++; $display("FAIL rstwait_drop got rd %h want 00000001", o.rd); end
  endtask

  task automatic test_byteen();
    obs_t o; logic [31:0] rd, want; logic er;
    model_acc(0, 1'b1, 32'd96, 32'h1122_3344, 4'hF, rd, er);
    xact(0, 1'b1, 32'd96, 32'h1122_3344, 4'hF, 0, o);
    model_acc(0, 1'b1, 32'd96, 32'hAABB_CCDD, 4'b0011, rd, er);
    xact(0, 1'b1, 32'd96, 32'hAABB_CCDD, 4'b0011, 0, o);
    checks++; if (o.er !== 1'b0 || o.rd !== 32'h0) begin errors++; $display("FAIL be_store_resp got err %b rd %h want 0 0", o.er, o.rd); end
    xact(0, 1'b0, 32'd96, 32'h0, 4'b0000, 0, o);
`ifdef DMEM_RESP_BYTEEN_EN
    want = 32'h1122_CCDD;
`else
    want = 32'hAABB_CCDD;
`endif
    checks++; if (o.rd !== want) begin errors++; $display("FAIL be_merge got %h want %h", o.rd, want); end
    model_acc(0, 1'b1, 32'd96, 32'h0, 4'b0000, rd, er);
    xact(0, 1'b1, 32'd96, 32'h0, 4'b0000, 0, o);
    checks++; if (o.er !== 1'b0 || o.lat != 2) begin errors++; $display("FAIL be_zero_resp got err %b lat %0d want 0 2", o.er, o.lat); end
    model_acc(0, 1'b0, 32'd96, 32'h0, 4'hF, rd, er);
    xact(0, 1'b0, 32'd96, 32'h0, 4'hF, 0, o);
    checks++; if (o.rd !== rd) begin errors++; $display("FAIL be_zero_readback got %h want %h", o.rd, rd); end
  endtask

  task automatic test_random(input int s);
    obs_t o; logic [31:0] a, wd, rd; logic [3:0] be; logic we, er; int w, hold;
    for (int i = 0; i < 40; i++) begin
      w    = $urandom_range(0, 69);
      a    = 32'(w * 4 + (($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0));
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      if (a % 4 == 0 && w < DEPTH && !known_m[s][w]) begin we = 1'b1; be = 4'hF; end
      model_acc(s, we, a, wd, be, rd, er);
      xact(s, we, a, wd, be, hold, o);
      checks++;
      if (o.lat != lat_of(s) || o.er !== er || o.rd !== rd || !o.stable || !o.idle_after) begin
        errors++;
        $display("FAIL rand[%0d.%0d] a=%h we=%b got lat %0d err %b rd %h stable %b idle %b want lat %0d err %b rd %h",
                 s, i, a, we, o.lat, o.er, o.rd, o.stable, o.idle_after, lat_of(s), er, rd);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0; req_wdata[s] = '0; resp_ready[s] = 1'b0;
`ifdef DMEM_RESP_BYTEEN_EN
      req_be[s] = 4'h0;
`endif
      for (int w = 0; w < DEPTH; w++) begin mem_m[s][w] = 'x; known_m[s][w] = 1'b0; end
    end
    test_reset();
    for (int s = 0; s < 2; s++) begin
      test_store_load(s);
      test_hold(s);
    end
    test_misaligned();
    test_range();
    test_reset_wait();
    test_byteen();
    test_random(0);
    test_random(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
